// File: rtl/dma_tcdm_pkg.sv
// Shared defaults and helpers for the DMA-to-TCDM request cut.
package dma_tcdm_pkg;

   localparam int unsigned DefAddrWidth = 32;
   localparam int unsigned DefDataWidth = 32;

   // Counter width able to hold 0..max_out inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/dma_tcdm_req_cut_fifo.sv
// Response FIFO for the TCDM request cut; registered output, no fall-through.
module dma_tcdm_req_cut_fifo #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 empty_o,
   output logic                 full_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW     = $clog2(Depth + 1);

   logic [DataWidth-1:0] mem_q [Depth];
   logic [PtrWidth-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 do_push, do_pop;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/dma_tcdm_req_cut.sv
// Request cut + credit-limited response buffer between a DMA bank port and a TCDM master.
// Optional DMA_TCDM_CUT_PERF_EN adds grant and stall counters.
module dma_tcdm_req_cut
   import dma_tcdm_pkg::*;
#(
   parameter int unsigned AddrWidth      = DefAddrWidth,
   parameter int unsigned DataWidth      = DefDataWidth,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned RspFifoDepth   = MaxOutstanding
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   mem_req_i,
   output logic                   mem_gnt_o,
   input  logic [AddrWidth-1:0]   mem_addr_i,
   input  logic                   mem_we_i,
   input  logic [DataWidth-1:0]   mem_wdata_i,
   input  logic [DataWidth/8-1:0] mem_strb_i,
   output logic                   mem_rvalid_o,
   input  logic                   mem_rready_i,
   output logic [DataWidth-1:0]   mem_rdata_o,
   output logic                   tcdm_req_o,
   input  logic                   tcdm_gnt_i,
   output logic [AddrWidth-1:0]   tcdm_add_o,
   output logic                   tcdm_wen_o,
   output logic [DataWidth-1:0]   tcdm_wdata_o,
   output logic [DataWidth/8-1:0] tcdm_be_o,
   input  logic                   tcdm_r_valid_i,
   input  logic [DataWidth-1:0]   tcdm_r_rdata_i,
   output logic                   busy_o,
   output logic                   err_o
`ifdef DMA_TCDM_CUT_PERF_EN
   ,
   output logic [31:0]            perf_gnt_o,
   output logic [31:0]            perf_stall_o
`endif
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned CntWidth  = cnt_width(MaxOutstanding);

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 we;
      logic [DataWidth-1:0] wdata;
      logic [StrbWidth-1:0] strb;
   } tcdm_req_t;

   if (MaxOutstanding < 1) begin : g_max_out_chk
      $error("dma_tcdm_req_cut: MaxOutstanding must be at least 1");
   end
   if (RspFifoDepth < MaxOutstanding) begin : g_depth_chk
      $error("dma_tcdm_req_cut: RspFifoDepth must be >= MaxOutstanding");
   end

   tcdm_req_t           req_q, req_d;
   logic                full_q, full_d;
   logic [CntWidth-1:0] out_q, out_d;
   logic                rdy_q, gnt_d_q, err_q;
   logic                accept, issue, pop, pop_cnt;
   logic                fifo_push, fifo_empty, fifo_full;

   assign tcdm_req_o   = full_q && (out_q < CntWidth'(MaxOutstanding));
   assign issue        = tcdm_req_o && tcdm_gnt_i;
   // rdy_q keeps the upstream grant low while in reset and for the first cycle after.
   assign mem_gnt_o    = rdy_q && (!full_q || issue);
   assign accept       = mem_req_i && mem_gnt_o;
   assign mem_rvalid_o = !fifo_empty;
   assign pop          = mem_rvalid_o && mem_rready_i;
   // A popped spurious response must not underflow the credit counter.
   assign pop_cnt      = pop && (out_q != '0);
   assign fifo_push    = tcdm_r_valid_i && !fifo_full;

   assign tcdm_add_o   = req_q.addr;
   assign tcdm_wen_o   = !req_q.we;
   assign tcdm_wdata_o = req_q.wdata;
   assign tcdm_be_o    = req_q.strb;
   assign busy_o       = full_q || (out_q != '0);
   assign err_o        = err_q;

   always_comb begin
      req_d  = req_q;
      full_d = full_q;
      out_d  = out_q;
      if (accept) begin
         req_d  = '{addr: mem_addr_i, we: mem_we_i, wdata: mem_wdata_i, strb: mem_strb_i};
         full_d = 1'b1;
      end else if (issue) begin
         full_d = 1'b0;
      end
      if (issue && !pop_cnt)      out_d = out_q + CntWidth'(1);
      else if (!issue && pop_cnt) out_d = out_q - CntWidth'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q   <= '0;
         full_q  <= 1'b0;
         out_q   <= '0;
         rdy_q   <= 1'b0;
         gnt_d_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         req_q   <= req_d;
         full_q  <= full_d;
         out_q   <= out_d;
         rdy_q   <= 1'b1;
         gnt_d_q <= issue;
         err_q   <= err_q || (tcdm_r_valid_i && !gnt_d_q);
      end
   end

   dma_tcdm_req_cut_fifo #(
      .DataWidth(DataWidth),
      .Depth    (RspFifoDepth)
   ) i_rsp_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (fifo_push),
      .data_i (tcdm_r_rdata_i),
      .pop_i  (pop),
      .data_o (mem_rdata_o),
      .empty_o(fifo_empty),
      .full_o (fifo_full)
   );

`ifdef DMA_TCDM_CUT_PERF_EN
   logic [31:0] perf_gnt_q, perf_stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_gnt_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (issue)                      perf_gnt_q   <= perf_gnt_q + 32'd1;
         if (tcdm_req_o && !tcdm_gnt_i) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_gnt_o   = perf_gnt_q;
   assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_dma_tcdm_req_cut.sv
// Bench for dma_tcdm_req_cut: cycle table for a single read, then scoreboarded sequences.
module tb_dma_tcdm_req_cut;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        mem_req_i, mem_gnt_o, mem_we_i;
   logic [31:0] mem_addr_i, mem_wdata_i;
   logic [3:0]  mem_strb_i;
   logic        mem_rvalid_o, mem_rready_i;
   logic [31:0] mem_rdata_o;
   logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
   logic [31:0] tcdm_add_o, tcdm_wdata_o, tcdm_r_rdata_i;
   logic [3:0]  tcdm_be_o;
   logic        busy_o, err_o;
`ifdef DMA_TCDM_CUT_PERF_EN
   logic [31:0] perf_gnt_o, perf_stall_o;
`endif

   always #5 clk_i = ~clk_i;

   dma_tcdm_req_cut dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
      .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
      .mem_rvalid_o(mem_rvalid_o), .mem_rready_i(mem_rready_i), .mem_rdata_o(mem_rdata_o),
      .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
      .tcdm_wen_o(tcdm_wen_o), .tcdm_wdata_o(tcdm_wdata_o), .tcdm_be_o(tcdm_be_o),
      .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
      .busy_o(busy_o), .err_o(err_o)
`ifdef DMA_TCDM_CUT_PERF_EN
      , .perf_gnt_o(perf_gnt_o), .perf_stall_o(perf_stall_o)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rsp_of(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } req_rec_t;

   req_rec_t    exp_req_q[$];
   logic [31:0] exp_rsp_q[$];
   int          gnt_seen = 0;
   int          rsp_pops = 0;

   // TCDM model: answers every grant one cycle later; scoreboard checks gated by sb_en.
   bit          model_en = 1'b0;
   bit          sb_en = 1'b0;
   bit          pend = 1'b0;
   logic [31:0] pend_data = '0;
   logic        mdl_vld = 1'b0, man_vld = 1'b0;
   logic [31:0] mdl_data = '0, man_data = '0;

   assign tcdm_r_valid_i = model_en ? mdl_vld : man_vld;
   assign tcdm_r_rdata_i = model_en ? mdl_data : man_data;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         pend = 1'b0;
      end else begin
         if (tcdm_req_o && tcdm_gnt_i) begin
            gnt_seen++;
            if (model_en) begin
               pend      = 1'b1;
               pend_data = rsp_of(tcdm_add_o);
            end
            if (sb_en) begin
               if (exp_req_q.size() == 0) chk("tcdm_unexpected_gnt", 32'd1, 32'd0);
               else begin
                  req_rec_t r;
                  r = exp_req_q.pop_front();
                  chk("tcdm_add", tcdm_add_o, r.addr);
                  chk("tcdm_wen", {31'd0, tcdm_wen_o}, {31'd0, !r.we});
                  chk("tcdm_wdata", tcdm_wdata_o, r.wdata);
                  chk("tcdm_be", {28'd0, tcdm_be_o}, {28'd0, r.strb});
               end
            end
         end
         if (sb_en && mem_rvalid_o && mem_rready_i) begin
            rsp_pops++;
            if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else chk("rsp_rdata", mem_rdata_o, exp_rsp_q.pop_front());
         end
      end
   end

   always @(posedge clk_i) begin
      #1;
      mdl_vld  = pend;
      mdl_data = pend_data;
      pend     = 1'b0;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sb);
      bit done;
      done        = 1'b0;
      mem_req_i   = 1'b1;
      mem_we_i    = we;
      mem_addr_i  = a;
      mem_wdata_i = wd;
      mem_strb_i  = sb;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk_i);
         if (mem_gnt_o) begin
            done = 1'b1;
            exp_req_q.push_back('{addr: a, we: we, wdata: wd, strb: sb});
            exp_rsp_q.push_back(rsp_of(a));
         end
         step();
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk_i);
         if (exp_rsp_q.size() == 0 && !busy_o && !mem_rvalid_o) done = 1'b1;
      end
      chk({tag, "_drain"}, {31'd0, done}, 32'd1);
      step();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_mem_gnt"},   {31'd0, mem_gnt_o},    32'd0);
      chk({tag, "_rvalid"},    {31'd0, mem_rvalid_o}, 32'd0);
      chk({tag, "_tcdm_req"},  {31'd0, tcdm_req_o},   32'd0);
      chk({tag, "_busy"},      {31'd0, busy_o},       32'd0);
      chk({tag, "_err"},       {31'd0, err_o},        32'd0);
      chk({tag, "_add"},       tcdm_add_o,            32'd0);
      chk({tag, "_wdata"},     tcdm_wdata_o,          32'd0);
      chk({tag, "_be"},        {28'd0, tcdm_be_o},    32'd0);
      chk({tag, "_wen"},       {31'd0, tcdm_wen_o},   32'd1);
`ifdef DMA_TCDM_CUT_PERF_EN
      chk({tag, "_perf_gnt"},   perf_gnt_o,   32'd0);
      chk({tag, "_perf_stall"}, perf_stall_o, 32'd0);
`endif
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #2;
      chk_reset("reset");
      step();
      rst_ni = 1'b1;
      step();
      step();
   endtask

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        e_mgnt;
      logic        e_treq;
      logic        e_rvalid;
      logic [31:0] e_rdata;
      logic [31:0] e_add;
      logic        e_busy;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int g0, p0;
      rst_ni = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
      mem_wdata_i = '0; mem_strb_i = '0; mem_rready_i = 1'b1; tcdm_gnt_i = 1'b0;

      // Single read at 0x1000_0040 driven cycle by cycle with a hand-driven TCDM.
      //            req  addr          gnt  rv   rd             mgnt treq rval rdata          add           busy
      vecs[0] = '{1'b1, 32'h1000_0040, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
      vecs[1] = '{1'b0, 32'h1000_0040, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'h1000_0040, 1'b1};
      vecs[2] = '{1'b0, 32'h1000_0040, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        32'h1000_0040, 1'b1};
      vecs[3] = '{1'b0, 32'h1000_0040, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h1000_0040, 1'b1};
      vecs[4] = '{1'b0, 32'h1000_0040, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h1000_0040, 1'b0};

      do_reset();

      for (int i = 0; i < 5; i++) begin
         mem_req_i  = vecs[i].req;
         mem_addr_i = vecs[i].addr;
         mem_we_i   = 1'b0;
         tcdm_gnt_i = vecs[i].gnt;
         man_vld    = vecs[i].rv;
         man_data   = vecs[i].rd;
         @(negedge clk_i);
         chk($sformatf("vec%0d_mem_gnt", i),  {31'd0, mem_gnt_o},    {31'd0, vecs[i].e_mgnt});
         chk($sformatf("vec%0d_tcdm_req", i), {31'd0, tcdm_req_o},   {31'd0, vecs[i].e_treq});
         chk($sformatf("vec%0d_rvalid", i),   {31'd0, mem_rvalid_o}, {31'd0, vecs[i].e_rvalid});
         chk($sformatf("vec%0d_add", i),      tcdm_add_o,            vecs[i].e_add);
         chk($sformatf("vec%0d_wen", i),      {31'd0, tcdm_wen_o},   32'd1);
         chk($sformatf("vec%0d_busy", i),     {31'd0, busy_o},       {31'd0, vecs[i].e_busy});
         chk($sformatf("vec%0d_err", i),      {31'd0, err_o},        32'd0);
         if (vecs[i].e_rvalid) chk($sformatf("vec%0d_rdata", i), mem_rdata_o, vecs[i].e_rdata);
         step();
      end
      man_vld = 1'b0;
      tcdm_gnt_i = 1'b0;

      // Eight back-to-back writes against an always-granting TCDM.
      model_en = 1'b1; sb_en = 1'b1; tcdm_gnt_i = 1'b1; mem_rready_i = 1'b1;
      p0 = rsp_pops;
      for (int i = 0; i < 8; i++)
         send(1'b1, 32'h0000_2000 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 4'hF);
      mem_req_i = 1'b0;
      drain("burst");
      chk("burst_rsp_count", 32'(rsp_pops - p0), 32'd8);
      chk("burst_busy_low", {31'd0, busy_o}, 32'd0);

      // Credit limit: rready low holds two grants; the third waits for pops.
      mem_rready_i = 1'b0;
      g0 = gnt_seen;
      send(1'b0, 32'h0000_4000, 32'h0, 4'hF);
      send(1'b0, 32'h0000_4004, 32'h0, 4'hF);
      send(1'b0, 32'h0000_4008, 32'h0, 4'hF);
      mem_req_i = 1'b0;
      repeat (4) step();
      @(negedge clk_i);
      chk("credit_tcdm_req_low", {31'd0, tcdm_req_o}, 32'd0);
      chk("credit_gnt_count", 32'(gnt_seen - g0), 32'd2);
      chk("credit_rvalid", {31'd0, mem_rvalid_o}, 32'd1);
      chk("credit_head", mem_rdata_o, rsp_of(32'h0000_4000));
      chk("credit_busy", {31'd0, busy_o}, 32'd1);
      step();
      mem_rready_i = 1'b1;
      drain("credit");
      chk("credit_gnt_total", 32'(gnt_seen - g0), 32'd3);

      // Grant withheld for five cycles: request held stable, upstream stalled.
      do_reset();
      tcdm_gnt_i = 1'b0;
      send(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'h5);
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_3004;
      mem_wdata_i = 32'h0BAD_F00D; mem_strb_i = 4'hA;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         chk($sformatf("stall%0d_tcdm_req", k), {31'd0, tcdm_req_o}, 32'd1);
         chk($sformatf("stall%0d_mem_gnt", k),  {31'd0, mem_gnt_o},  32'd0);
         chk($sformatf("stall%0d_add", k),      tcdm_add_o,          32'h0000_3000);
         chk($sformatf("stall%0d_wdata", k),    tcdm_wdata_o,        32'hCAFE_F00D);
         chk($sformatf("stall%0d_be", k),       {28'd0, tcdm_be_o},  32'h5);
         step();
      end
`ifdef DMA_TCDM_CUT_PERF_EN
      chk("perf_stall_5", perf_stall_o, 32'd5);
`endif
      tcdm_gnt_i = 1'b1;
      send(1'b1, 32'h0000_3004, 32'h0BAD_F00D, 4'hA);
      mem_req_i = 1'b0;
      drain("stall");
`ifdef DMA_TCDM_CUT_PERF_EN
      chk("perf_gnt_2", perf_gnt_o, 32'd2);
      chk("perf_stall_hold", perf_stall_o, 32'd5);
`endif

      // Spurious response with nothing granted.
      model_en = 1'b0; sb_en = 1'b0;
      @(negedge clk_i);
      chk("spur_err_before", {31'd0, err_o}, 32'd0);
      step();
      man_vld = 1'b1; man_data = 32'h1234_5678;
      step();
      man_vld = 1'b0;
      @(negedge clk_i);
      chk("spur_err_set", {31'd0, err_o}, 32'd1);
      chk("spur_rvalid", {31'd0, mem_rvalid_o}, 32'd1);
      chk("spur_rdata", mem_rdata_o, 32'h1234_5678);
      step();
      @(negedge clk_i);
      chk("spur_rvalid_gone", {31'd0, mem_rvalid_o}, 32'd0);
      chk("spur_busy_low", {31'd0, busy_o}, 32'd0);
      repeat (3) step();
      @(negedge clk_i);
      chk("spur_err_sticky", {31'd0, err_o}, 32'd1);
      step();

      // Reset asserted in the middle of a read burst.
      model_en = 1'b1; tcdm_gnt_i = 1'b1; mem_rready_i = 1'b0;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_5000;
      repeat (3) step();
      @(negedge clk_i);
      chk("midrst_busy_before", {31'd0, busy_o}, 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_reset("midrst");
      mem_req_i = 1'b0;
      exp_req_q.delete();
      exp_rsp_q.delete();
      step();
      rst_ni = 1'b1;
      repeat (3) step();
      @(negedge clk_i);
      chk("post_rst_rvalid", {31'd0, mem_rvalid_o}, 32'd0);
      chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("post_rst_mem_gnt", {31'd0, mem_gnt_o}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
